// File: rtl/udp_frame_builder.sv
// rtl/udp_frame_builder.sv - buffers a UDP payload and emits an Ethernet/IPv4/UDP frame (MIN_FRAME_PAD_EN: pad to 60 bytes)
module udp_frame_builder #(
    parameter int         FIFO_DEPTH = 256,
    parameter logic [7:0] IP_TTL     = 8'd64
) (
    input  logic        axis_clk,
    input  logic        axis_resetn,
    input  logic [47:0] dest_addr,
    input  logic [47:0] src_addr,
    input  logic [31:0] ip_dest_addr,
    input  logic [31:0] ip_src_addr,
    input  logic [15:0] udp_dest_port,
    input  logic [15:0] udp_src_port,
    input  logic        hdr_valid,
    output logic        hdr_ready,
    input  logic [31:0] s_axis_tdata,
    input  logic [3:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH * 4) + 1;
    localparam int FW = LW + 1;
    localparam logic [LW-1:0] L_MAX = LW'(FIFO_DEPTH * 4);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_CSUM    = 2'd2;
    localparam logic [1:0] S_SEND    = 2'd3;

    logic [1:0]    state;
    logic [47:0]   dest_q, src_q;
    logic [31:0]   ip_dst_q, ip_src_q;
    logic [15:0]   udp_dst_q, udp_src_q;
    logic [15:0]   ip_id, total_len, udp_len, csum;
    logic [15:0]   hold;           // upper half of the previous FIFO word, emitted in lanes 0-1
    logic [LW-1:0] byte_cnt, keep_pop, cnt_next;
    logic [FW-1:0] frame_len, out_len, beat_idx, n_beats, fl_calc;
    logic [AW:0]   wr_cnt;
    logic          ovf_seen, fifo_full, fifo_we, beat_is_hdr, beat_last;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [31:0]   rd_word, beat_raw, beat_data;
    logic [3:0]    beat_keep;
    logic [7:0]    hb [40];
    logic [31:0]   hdr_words [16];
    logic [FW+1:0] lane_pos;
    logic [31:0]   sum0;
    logic [16:0]   sum1;
    logic [15:0]   sum2, tl_calc;

    assign hdr_ready     = (state == S_IDLE);
    assign s_axis_tready = (state == S_COLLECT);
    assign fifo_full     = (wr_cnt == (AW+1)'(FIFO_DEPTH));
    assign fifo_we       = axis_resetn && (state == S_COLLECT) && s_axis_tvalid && !fifo_full;

    assign keep_pop = LW'(s_axis_tkeep[0]) + LW'(s_axis_tkeep[1])
                    + LW'(s_axis_tkeep[2]) + LW'(s_axis_tkeep[3]);
    assign cnt_next = ((byte_cnt + keep_pop) > L_MAX) ? L_MAX : (byte_cnt + keep_pop);

    // Checksum over the ten IPv4 header halfwords with the checksum field taken as zero.
    always_comb begin
        tl_calc = 16'(byte_cnt) + 16'd28;
        sum0 = 32'h4500 + 32'(tl_calc) + 32'(ip_id) + 32'h4000 + 32'({IP_TTL, 8'h11})
             + 32'(ip_src_q[31:16]) + 32'(ip_src_q[15:0])
             + 32'(ip_dst_q[31:16]) + 32'(ip_dst_q[15:0]);
        sum1 = 17'(sum0[15:0]) + 17'(sum0[31:16]);
        sum2 = sum1[15:0] + 16'(sum1[16]);
        fl_calc = FW'(byte_cnt) + FW'(42);
    end

    // Header bytes 0-39; bytes 40-41 (UDP checksum) are zero and come from the cleared holdover.
    always_comb begin
        for (int i = 0; i < 40; i++) hb[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            hb[i]     = dest_q[47-8*i -: 8];
            hb[6 + i] = src_q[47-8*i -: 8];
        end
        hb[12] = 8'h08;             hb[13] = 8'h00;
        hb[14] = 8'h45;             hb[15] = 8'h00;
        hb[16] = total_len[15:8];   hb[17] = total_len[7:0];
        hb[18] = ip_id[15:8];       hb[19] = ip_id[7:0];
        hb[20] = 8'h40;             hb[21] = 8'h00;
        hb[22] = IP_TTL;            hb[23] = 8'h11;
        hb[24] = csum[15:8];        hb[25] = csum[7:0];
        for (int i = 0; i < 4; i++) begin
            hb[26 + i] = ip_src_q[31-8*i -: 8];
            hb[30 + i] = ip_dst_q[31-8*i -: 8];
        end
        hb[34] = udp_src_q[15:8];   hb[35] = udp_src_q[7:0];
        hb[36] = udp_dst_q[15:8];   hb[37] = udp_dst_q[7:0];
        hb[38] = udp_len[15:8];     hb[39] = udp_len[7:0];
        for (int w = 0; w < 16; w++) hdr_words[w] = 32'h0;
        for (int w = 0; w < 10; w++) hdr_words[w] = {hb[4*w+3], hb[4*w+2], hb[4*w+1], hb[4*w]};
    end

    assign beat_is_hdr = (beat_idx < FW'(10));
    assign rd_word     = mem[AW'(beat_idx - FW'(10))];
    assign n_beats     = (out_len + FW'(3)) >> 2;
    assign beat_last   = (beat_idx == n_beats - FW'(1));

    // Bytes past the real frame length (tail lanes, pad bytes) are forced to zero.
    always_comb begin
        beat_data = 32'h0;
        beat_keep = 4'h0;
        lane_pos  = '0;
        beat_raw  = beat_is_hdr ? hdr_words[beat_idx[3:0]] : {rd_word[15:0], hold};
        for (int k = 0; k < 4; k++) begin
            lane_pos = {beat_idx, 2'(k)};
            beat_data[8*k +: 8] = (lane_pos < {2'b00, frame_len}) ? beat_raw[8*k +: 8] : 8'h00;
            beat_keep[k]        = (lane_pos < {2'b00, out_len});
        end
    end

    always_ff @(posedge axis_clk) begin
        if (fifo_we) mem[wr_cnt[AW-1:0]] <= s_axis_tdata;
    end

    always_ff @(posedge axis_clk) begin
        if (!axis_resetn) begin
            state <= S_IDLE;
            dest_q <= '0; src_q <= '0; ip_dst_q <= '0; ip_src_q <= '0;
            udp_dst_q <= '0; udp_src_q <= '0;
            ip_id <= 16'h0; total_len <= 16'h0; udp_len <= 16'h0; csum <= 16'h0; hold <= 16'h0;
            byte_cnt <= '0; frame_len <= '0; out_len <= '0; beat_idx <= '0;
            wr_cnt <= '0; ovf_seen <= 1'b0; overflow <= 1'b0;
            m_axis_tdata <= 32'h0; m_axis_tkeep <= 4'h0; m_axis_tvalid <= 1'b0; m_axis_tlast <= 1'b0;
        end else begin
            overflow <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hdr_valid) begin
                        dest_q <= dest_addr; src_q <= src_addr;
                        ip_dst_q <= ip_dest_addr; ip_src_q <= ip_src_addr;
                        udp_dst_q <= udp_dest_port; udp_src_q <= udp_src_port;
                        byte_cnt <= '0; wr_cnt <= '0; ovf_seen <= 1'b0;
                        state <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (s_axis_tvalid) begin
                        if (fifo_full) begin
                            if (!ovf_seen) begin
                                overflow <= 1'b1;
                                ovf_seen <= 1'b1;
                            end
                        end else begin
                            wr_cnt   <= wr_cnt + (AW+1)'(1);
                            byte_cnt <= cnt_next;
                        end
                        if (s_axis_tlast) state <= S_CSUM;
                    end
                end
                S_CSUM: begin
                    total_len <= tl_calc;
                    udp_len   <= 16'(byte_cnt) + 16'd8;
                    csum      <= ~sum2;
                    frame_len <= fl_calc;
`ifdef MIN_FRAME_PAD_EN
                    out_len   <= (fl_calc < FW'(60)) ? FW'(60) : fl_calc;
`else
                    out_len   <= fl_calc;
`endif
                    beat_idx  <= '0;
                    hold      <= 16'h0;
                    state     <= S_SEND;
                end
                default: begin
                    if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                        m_axis_tdata  <= 32'h0;
                        m_axis_tkeep  <= 4'h0;
                        ip_id         <= ip_id + 16'd1;
                        state         <= S_IDLE;
                    end else if (!m_axis_tvalid || m_axis_tready) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= beat_data;
                        m_axis_tkeep  <= beat_keep;
                        m_axis_tlast  <= beat_last;
                        beat_idx      <= beat_idx + FW'(1);
                        if (!beat_is_hdr) hold <= rd_word[31:16];
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_udp_frame_builder.sv
// tb/tb_udp_frame_builder.sv - self-checking bench for udp_frame_builder
`timescale 1ns/1ps
module tb_udp_frame_builder;
    logic        axis_clk = 1'b0;
    logic        axis_resetn = 1'b0;
    logic [47:0] dest_addr = '0, src_addr = '0;
    logic [31:0] ip_dest_addr = '0, ip_src_addr = '0;
    logic [15:0] udp_dest_port = '0, udp_src_port = '0;
    logic        hdr_valid = 1'b0;
    logic        hdr_ready;
    logic [31:0] s_axis_tdata = '0;
    logic [3:0]  s_axis_tkeep = '0;
    logic        s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid, m_axis_tlast;
    logic        m_axis_tready = 1'b1;
    logic        overflow;

    always #5 axis_clk = ~axis_clk;

    udp_frame_builder dut (
        .axis_clk(axis_clk), .axis_resetn(axis_resetn),
        .dest_addr(dest_addr), .src_addr(src_addr),
        .ip_dest_addr(ip_dest_addr), .ip_src_addr(ip_src_addr),
        .udp_dest_port(udp_dest_port), .udp_src_port(udp_src_port),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .overflow(overflow)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ovf_pulses = 0;
    always @(posedge axis_clk) cyc <= cyc + 1;
    always @(negedge axis_clk) if (overflow === 1'b1) ovf_pulses <= ovf_pulses + 1;

    logic [47:0] m_dst = 48'h02_00_00_00_00_01, m_src = 48'h02_00_00_00_00_02;
    logic [31:0] m_ips = 32'h0a00_0001, m_ipd = 32'h0a00_0002;
    logic [15:0] m_usp = 16'd1000, m_udp = 16'd2000;
    logic [15:0] exp_id = 16'h0;
    logic [31:0] pay_w[$];
    logic [3:0]  pay_k[$];
    logic [7:0]  pay_bytes[$];
    logic [7:0]  exp_b[$];
    logic [31:0] cap_d[$];
    logic [3:0]  cap_k[$];
    logic        cap_l[$];
    int tlast_cyc = 0, lat = 0, stall_err = 0, ovf_base = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ip_csum(input logic [15:0] tl, input logic [15:0] id);
        logic [31:0] s;
        s = 32'h4500 + 32'(tl) + 32'(id) + 32'h4000 + 32'h4011
          + 32'(m_ips[31:16]) + 32'(m_ips[15:0]) + 32'(m_ipd[31:16]) + 32'(m_ipd[15:0]);
        while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        return ~s[15:0];
    endfunction

    function automatic logic [7:0] cap_byte(input int n);
        logic [31:0] w;
        if (n / 4 >= cap_d.size()) return 8'h00;
        w = cap_d[n / 4] >> (8 * (n % 4));
        return w[7:0];
    endfunction

    function automatic logic [15:0] cap_half(input int n);
        return {cap_byte(n), cap_byte(n + 1)};
    endfunction

    function automatic logic [15:0] hdr_sum();
        logic [31:0] s = 32'h0;
        for (int n = 14; n < 34; n += 2) s += 32'(cap_half(n));
        while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        return s[15:0];
    endfunction

    task automatic clear_payload();
        pay_w.delete(); pay_k.delete(); pay_bytes.delete();
    endtask

    task automatic add_word(input logic [31:0] d, input logic [3:0] k);
        pay_w.push_back(d);
        pay_k.push_back(k);
        for (int l = 0; l < 4; l++) if (k[l]) pay_bytes.push_back(d[8*l +: 8]);
    endtask

    task automatic build_expected();
        int L;
        logic [15:0] tl, ul, cs;
        exp_b.delete();
        L  = (pay_bytes.size() > 1024) ? 1024 : pay_bytes.size();
        tl = 16'(28 + L);
        ul = 16'(8 + L);
        cs = ip_csum(tl, exp_id);
        for (int i = 0; i < 6; i++) exp_b.push_back(m_dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) exp_b.push_back(m_src[47-8*i -: 8]);
        exp_b.push_back(8'h08); exp_b.push_back(8'h00); exp_b.push_back(8'h45); exp_b.push_back(8'h00);
        exp_b.push_back(tl[15:8]); exp_b.push_back(tl[7:0]);
        exp_b.push_back(exp_id[15:8]); exp_b.push_back(exp_id[7:0]);
        exp_b.push_back(8'h40); exp_b.push_back(8'h00); exp_b.push_back(8'h40); exp_b.push_back(8'h11);
        exp_b.push_back(cs[15:8]); exp_b.push_back(cs[7:0]);
        for (int i = 0; i < 4; i++) exp_b.push_back(m_ips[31-8*i -: 8]);
        for (int i = 0; i < 4; i++) exp_b.push_back(m_ipd[31-8*i -: 8]);
        exp_b.push_back(m_usp[15:8]); exp_b.push_back(m_usp[7:0]);
        exp_b.push_back(m_udp[15:8]); exp_b.push_back(m_udp[7:0]);
        exp_b.push_back(ul[15:8]); exp_b.push_back(ul[7:0]);
        exp_b.push_back(8'h00); exp_b.push_back(8'h00);
        for (int j = 0; j < L; j++) exp_b.push_back(pay_bytes[j]);
`ifdef MIN_FRAME_PAD_EN
        while (exp_b.size() < 60) exp_b.push_back(8'h00);
`endif
    endtask

    task automatic send_header();
        int budget = 100;
        @(negedge axis_clk);
        while (!hdr_ready && budget > 0) begin
            @(negedge axis_clk);
            budget--;
        end
        check_eq("hdr_ready_wait", hdr_ready, 1'b1);
        dest_addr = m_dst; src_addr = m_src; ip_dest_addr = m_ipd; ip_src_addr = m_ips;
        udp_dest_port = m_udp; udp_src_port = m_usp; hdr_valid = 1'b1;
        @(negedge axis_clk);
        hdr_valid = 1'b0;
    endtask

    task automatic drive_payload(input bit bogus_hdr);
        int i = 0;
        int budget = 2000;
        while (i < pay_w.size() && budget > 0) begin
            @(negedge axis_clk);
            budget--;
            s_axis_tdata  = pay_w[i];
            s_axis_tkeep  = pay_k[i];
            s_axis_tlast  = (i == pay_w.size() - 1);
            s_axis_tvalid = 1'b1;
            hdr_valid     = bogus_hdr && (i == 0);
            dest_addr     = (bogus_hdr && i == 0) ? 48'hffff_ffff_ffff : m_dst;
            if (s_axis_tready) begin
                if (s_axis_tlast) tlast_cyc = cyc + 1;
                i++;
            end
        end
        @(negedge axis_clk);
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; hdr_valid = 1'b0; dest_addr = m_dst;
        check_eq("payload_accepted", i, pay_w.size());
    endtask

    task automatic collect(input int mode, input int max_beats);
        int budget = 3000;
        bit done = 0, first = 0, pending = 0, tog = 1;
        logic [31:0] pd = '0;
        logic [3:0] pk = '0;
        cap_d.delete(); cap_k.delete(); cap_l.delete();
        stall_err = 0;
        while (!done && budget > 0) begin
            @(negedge axis_clk);
            budget--;
            if (pending && (m_axis_tdata !== pd || m_axis_tkeep !== pk || m_axis_tvalid !== 1'b1))
                stall_err++;
            if (!first && m_axis_tvalid) begin
                first = 1;
                lat = cyc - tlast_cyc;
            end
            m_axis_tready = (mode == 0) ? 1'b1 : tog;
            tog = ~tog;
            if (m_axis_tvalid && m_axis_tready) begin
                cap_d.push_back(m_axis_tdata); cap_k.push_back(m_axis_tkeep); cap_l.push_back(m_axis_tlast);
                pending = 0;
                if (m_axis_tlast || cap_d.size() == max_beats) done = 1;
            end else if (m_axis_tvalid) begin
                pending = 1; pd = m_axis_tdata; pk = m_axis_tkeep;
            end
        end
        check_eq("collect_done", done, 1'b1);
    endtask

    task automatic compare_frame(input string tag);
        int nb;
        logic [31:0] ed;
        logic [3:0] ek;
        build_expected();
        nb = (exp_b.size() + 3) / 4;
        check_eq({tag, "_beats"}, cap_d.size(), nb);
        for (int b = 0; b < nb && b < cap_d.size(); b++) begin
            ed = '0; ek = '0;
            for (int l = 0; l < 4; l++) if (4*b + l < exp_b.size()) begin
                ed[8*l +: 8] = exp_b[4*b + l];
                ek[l] = 1'b1;
            end
            check_eq($sformatf("%s_data%0d", tag, b), cap_d[b], ed);
            check_eq($sformatf("%s_keep%0d", tag, b), cap_k[b], ek);
            check_eq($sformatf("%s_last%0d", tag, b), cap_l[b], b == nb - 1);
        end
    endtask

    task automatic run_frame(input string tag, input int mode, input bit bogus);
        send_header();
        drive_payload(bogus);
        collect(mode, 100000);
        compare_frame(tag);
        exp_id++;
    endtask

    task automatic load_frame_a();
        clear_payload();
        add_word(32'h0302_0100, 4'hf);
        add_word(32'h0706_0504, 4'hf);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_hdr_ready"}, hdr_ready, 1'b1);
        check_eq({tag, "_s_tready"}, s_axis_tready, 1'b0);
        check_eq({tag, "_m_tvalid"}, m_axis_tvalid, 1'b0);
        check_eq({tag, "_m_tlast"}, m_axis_tlast, 1'b0);
        check_eq({tag, "_m_tdata"}, m_axis_tdata, 32'h0);
        check_eq({tag, "_m_tkeep"}, m_axis_tkeep, 4'h0);
        check_eq({tag, "_overflow"}, overflow, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge axis_clk);
        check_idle_outputs("rst");
        axis_resetn = 1'b1;

        // Two-word payload, hand-derived header fields and realignment.
        load_frame_a();
        run_frame("a", 0, 0);
        check_eq("a_total_len", cap_half(16), 16'h0024);
        check_eq("a_udp_len", cap_half(38), 16'h0010);
        check_eq("a_id", cap_half(18), 16'h0000);
        check_eq("a_csum", cap_half(24), 16'h26c7);
        check_eq("a_hdr_sum", hdr_sum(), 16'hffff);
        check_eq("a_beat10", cap_d[10], 32'h0100_0000);
        check_eq("a_beat11", cap_d[11], 32'h0504_0302);
        check_eq("a_beat12", cap_d[12], 32'h0000_0706);
        check_eq("a_latency", lat, 2);
`ifdef MIN_FRAME_PAD_EN
        check_eq("a_nbeats", cap_d.size(), 15);
        check_eq("a_keep12", cap_k[12], 4'hf);
`else
        check_eq("a_nbeats", cap_d.size(), 13);
        check_eq("a_keep12", cap_k[12], 4'h3);
`endif

        // One-byte payload with junk in unused lanes; hdr_valid pulsed mid-collect must be ignored.
        clear_payload();
        add_word(32'hdead_beab, 4'h1);
        run_frame("b", 0, 1);
        check_eq("b_total_len", cap_half(16), 16'h001d);
        check_eq("b_byte42", cap_byte(42), 8'hab);
        check_eq("b_dst_hi", cap_half(0), 16'h0200);
`ifdef MIN_FRAME_PAD_EN
        check_eq("b_nbeats", cap_d.size(), 15);
`else
        check_eq("b_nbeats", cap_d.size(), 11);
        check_eq("b_lastkeep", cap_k[10], 4'h7);
`endif

        // Back-pressure toggling every cycle.
        load_frame_a();
        run_frame("c", 1, 0);
        check_eq("c_stall_hold", stall_err, 0);

        // Overflow: 300 full beats into a 256-word buffer.
        clear_payload();
        for (int i = 0; i < 300; i++)
            add_word({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 4'hf);
        ovf_base = ovf_pulses;
        run_frame("ovf", 0, 0);
        check_eq("ovf_pulses", ovf_pulses - ovf_base, 1);
        check_eq("ovf_total_len", cap_half(16), 16'h041c);
        check_eq("ovf_udp_len", cap_half(38), 16'h0408);
        check_eq("ovf_nbeats", cap_d.size(), 267);
        check_eq("ovf_lastkeep", cap_k[266], 4'h3);
        @(negedge axis_clk);
        check_eq("ovf_hdr_ready", hdr_ready, 1'b1);

        // Reset, then back-to-back frames; abort the second one at beat 5.
        axis_resetn = 1'b0;
        repeat (2) @(negedge axis_clk);
        axis_resetn = 1'b1;
        exp_id = 16'h0;
        load_frame_a();
        run_frame("bb1", 0, 0);
        check_eq("bb1_id", cap_half(18), 16'h0000);
        send_header();
        drive_payload(0);
        collect(0, 5);
        check_eq("bb2_id", cap_half(18), 16'h0001);
        @(negedge axis_clk);
        axis_resetn = 1'b0;
        @(negedge axis_clk);
        check_idle_outputs("midrst");
        axis_resetn = 1'b1;
        @(negedge axis_clk);
        check_eq("post_rst_hdr_ready", hdr_ready, 1'b1);
        check_eq("post_rst_tvalid", m_axis_tvalid, 1'b0);
        exp_id = 16'h0;
        run_frame("bb3", 0, 0);
        check_eq("bb3_id", cap_half(18), 16'h0000);

        // Four-byte payload: padded or exact-length frame depending on build.
        clear_payload();
        add_word(32'h4433_2211, 4'hf);
        run_frame("pad", 0, 0);
        check_eq("pad_total_len", cap_half(16), 16'h0020);
`ifdef MIN_FRAME_PAD_EN
        check_eq("pad_nbeats", cap_d.size(), 15);
        check_eq("pad_lastkeep", cap_k[14], 4'hf);
        for (int n = 46; n < 60; n++) check_eq($sformatf("pad_byte%0d", n), cap_byte(n), 8'h00);
`else
        check_eq("pad_nbeats", cap_d.size(), 12);
        check_eq("pad_lastkeep", cap_k[11], 4'h3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
